// File: rtl/hist_stat_param.sv
// Gray-level histogram engine: clears bins, accumulates one frame, then dumps every bin
// (PDF or clipped CDF) in level order over a valid/ready handshake.
module hist_stat_param #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              img_vsync,
    input  logic              img_href,
    input  logic [DATA_W-1:0] img_gray,
    input  logic              cfg_cdf_mode,
    input  logic [CNT_W-1:0]  cfg_clip_limit,
    input  logic              out_ready,
    output logic [DATA_W-1:0] pixel_level,
    output logic [CNT_W-1:0]  pixel_level_num,
    output logic              pixel_level_valid,
    output logic [CNT_W-1:0]  frame_pixel_total,
    output logic              busy,
    output logic              frame_overrun
);

    localparam int unsigned       NBIN    = 2 ** DATA_W;
    localparam logic [CNT_W-1:0]  CntMax  = '1;
    localparam logic [DATA_W-1:0] LastBin = '1;

    typedef enum logic [1:0] {StClear, StAccum, StDump} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] idx_q, idx_d;
    logic              done_q, done_d;
    logic              vsync_q, vsync_d;
    logic [CNT_W-1:0]  pix_cnt_q, pix_cnt_d;
    logic [CNT_W-1:0]  total_q, total_d;
    logic              cdf_mode_q, cdf_mode_d;
    logic [CNT_W-1:0]  clip_q, clip_d;
    logic [CNT_W-1:0]  cdf_acc_q, cdf_acc_d;
    logic [DATA_W-1:0] lvl_q, lvl_d;
    logic [CNT_W-1:0]  num_q, num_d;
    logic              valid_q, valid_d;
    logic              ovr_seen_q, ovr_seen_d;
    logic              ovr_q, ovr_d;

    logic [CNT_W-1:0]  bin_mem [NBIN];
    logic              wr_en;
    logic [DATA_W-1:0] wr_addr;
    logic [CNT_W-1:0]  wr_data;

    logic [CNT_W-1:0]  acc_rd, dump_rd, clipped, pix_next, cdf_sat;
    logic [CNT_W:0]    cdf_sum;
    logic              vsync_fall;

    // Accumulation is a same-cycle read-modify-write, so back-to-back equal levels
    // always see the freshly written count.
    assign acc_rd     = bin_mem[img_gray];
    assign dump_rd    = bin_mem[idx_q];
    assign vsync_fall = vsync_q & ~img_vsync;
    assign clipped    = (clip_q != '0 && dump_rd > clip_q) ? clip_q : dump_rd;
    assign cdf_sum    = {1'b0, cdf_acc_q} + {1'b0, clipped};
    assign cdf_sat    = cdf_sum[CNT_W] ? CntMax : cdf_sum[CNT_W-1:0];
    assign pix_next   = (img_href && pix_cnt_q != CntMax) ? pix_cnt_q + 1'b1 : pix_cnt_q;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        done_d     = done_q;
        vsync_d    = img_vsync;
        pix_cnt_d  = pix_cnt_q;
        total_d    = total_q;
        cdf_mode_d = cdf_mode_q;
        clip_d     = clip_q;
        cdf_acc_d  = cdf_acc_q;
        lvl_d      = lvl_q;
        num_d      = num_q;
        valid_d    = valid_q;
        ovr_seen_d = ovr_seen_q;
        ovr_d      = 1'b0;
        wr_en      = 1'b0;
        wr_addr    = idx_q;
        wr_data    = '0;

        unique case (state_q)
            StClear: begin
                wr_en = 1'b1;
                idx_d = idx_q + 1'b1;
                if (idx_q == LastBin) state_d = StAccum;
            end
            StAccum: begin
                ovr_seen_d = 1'b0;
                if (img_href) begin
                    wr_en   = 1'b1;
                    wr_addr = img_gray;
                    wr_data = (acc_rd == CntMax) ? CntMax : acc_rd + 1'b1;
                end
                if (vsync_fall) begin
                    state_d    = StDump;
                    total_d    = pix_next;
                    pix_cnt_d  = '0;
                    idx_d      = '0;
                    done_d     = 1'b0;
                    cdf_acc_d  = '0;
                    cdf_mode_d = cfg_cdf_mode;
                    clip_d     = cfg_clip_limit;
                end else begin
                    pix_cnt_d = pix_next;
                end
            end
            StDump: begin
                if (valid_q && out_ready && lvl_q == LastBin) begin
                    state_d = StAccum;
                    valid_d = 1'b0;
                end else if ((!valid_q || out_ready) && !done_q) begin
                    // Read-and-clear the next bin into the output register.
                    wr_en     = 1'b1;
                    lvl_d     = idx_q;
                    num_d     = cdf_mode_q ? cdf_sat : clipped;
                    valid_d   = 1'b1;
                    cdf_acc_d = cdf_sat;
                    idx_d     = idx_q + 1'b1;
                    if (idx_q == LastBin) done_d = 1'b1;
                end else if (valid_q && out_ready) begin
                    valid_d = 1'b0;
                end
            end
            default: state_d = StClear;
        endcase

        if (img_href && state_q != StAccum && !ovr_seen_q) begin
            ovr_d      = 1'b1;
            ovr_seen_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) bin_mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StClear;
            idx_q      <= '0;
            done_q     <= 1'b0;
            vsync_q    <= 1'b0;
            pix_cnt_q  <= '0;
            total_q    <= '0;
            cdf_mode_q <= 1'b0;
            clip_q     <= '0;
            cdf_acc_q  <= '0;
            lvl_q      <= '0;
            num_q      <= '0;
            valid_q    <= 1'b0;
            ovr_seen_q <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            done_q     <= done_d;
            vsync_q    <= vsync_d;
            pix_cnt_q  <= pix_cnt_d;
            total_q    <= total_d;
            cdf_mode_q <= cdf_mode_d;
            clip_q     <= clip_d;
            cdf_acc_q  <= cdf_acc_d;
            lvl_q      <= lvl_d;
            num_q      <= num_d;
            valid_q    <= valid_d;
            ovr_seen_q <= ovr_seen_d;
            ovr_q      <= ovr_d;
        end
    end

    assign pixel_level       = lvl_q;
    assign pixel_level_num   = num_q;
    assign pixel_level_valid = valid_q;
    assign frame_pixel_total = total_q;
    assign busy              = (state_q != StAccum);
    assign frame_overrun     = ovr_q;

endmodule
